// File: rtl/pipeline_fetch_unit_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory req/gnt/rvalid port and the ID valid/ready port.
// if_fault is present only when IF_MISALIGN_TRAP_EN is defined.
interface pipeline_fetch_unit_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            im_req;
  logic [XLEN-1:0] im_addr;
  logic            im_gnt;
  logic            im_rvalid;
  logic [ILEN-1:0] im_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [ILEN-1:0] if_instr;
`ifdef IF_MISALIGN_TRAP_EN
  logic            if_fault;

  modport master (
    input  redirect_valid, redirect_pc, im_gnt, im_rvalid, im_rdata, if_ready,
    output im_req, im_addr, if_valid, if_pc, if_instr, if_fault
  );
  modport slave (
    output redirect_valid, redirect_pc, im_gnt, im_rvalid, im_rdata, if_ready,
    input  im_req, im_addr, if_valid, if_pc, if_instr, if_fault
  );
`else
  modport master (
    input  redirect_valid, redirect_pc, im_gnt, im_rvalid, im_rdata, if_ready,
    output im_req, im_addr, if_valid, if_pc, if_instr
  );
  modport slave (
    output redirect_valid, redirect_pc, im_gnt, im_rvalid, im_rdata, if_ready,
    input  im_req, im_addr, if_valid, if_pc, if_instr
  );
`endif
endinterface

// File: rtl/pipeline_fetch_unit.sv
// Instruction-fetch stage: credit-limited in-flight requests, FWFT fetch buffer, redirect flush with stale-response drop.
// Optional misaligned-redirect fault entry selected by IF_MISALIGN_TRAP_EN.
module pipeline_fetch_unit #(
  parameter int unsigned     XLEN       = 64,
  parameter int unsigned     ILEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_fetch_unit_if.master bus
);
  localparam int unsigned     CW      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned     AW      = $clog2(FIFO_DEPTH);
  localparam logic [XLEN-1:0] STEP    = XLEN'(4);
  localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);

  logic [XLEN-1:0] fetch_pc, resp_pc, target_pc, push_pc;
  logic [ILEN-1:0] push_instr;
  logic [CW-1:0]   count, outstanding, drop_cnt, outstanding_next;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [XLEN-1:0] pc_mem    [FIFO_DEPTH];
  logic [ILEN-1:0] instr_mem [FIFO_DEPTH];
  logic            credit_ok, halted, accept, drop, push_resp, push, pop;

`ifdef IF_MISALIGN_TRAP_EN
  logic fault_mem [FIFO_DEPTH];
  logic fault_pending, misaligned;

  assign target_pc  = bus.redirect_pc;
  assign misaligned = |bus.redirect_pc[1:0];
  // A pending fault entry replaces the memory response path for its one push cycle.
  assign push       = !bus.redirect_valid && (fault_pending || push_resp);
  assign push_instr = fault_pending ? '0 : bus.im_rdata;
  assign bus.if_fault = fault_mem[rd_ptr];
`else
  assign target_pc  = bus.redirect_pc & ~XLEN'(3);
  assign halted     = 1'b0;
  assign push       = !bus.redirect_valid && push_resp;
  assign push_instr = bus.im_rdata;
`endif

  assign push_pc   = resp_pc;
  assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_W;
  assign accept    = bus.im_req && bus.im_gnt;
  assign drop      = bus.im_rvalid && (drop_cnt != '0);
  assign push_resp = bus.im_rvalid && (drop_cnt == '0);
  assign pop       = bus.if_valid && bus.if_ready;
  assign outstanding_next = outstanding + CW'(accept) - CW'(bus.im_rvalid);

  assign bus.im_req   = !reset && !bus.redirect_valid && !halted && credit_ok;
  assign bus.im_addr  = fetch_pc;
  assign bus.if_valid = !reset && !bus.redirect_valid && (count != '0);
  assign bus.if_pc    = pc_mem[rd_ptr];
  assign bus.if_instr = instr_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
`ifdef IF_MISALIGN_TRAP_EN
      halted        <= 1'b0;
      fault_pending <= 1'b0;
`endif
    end else if (bus.redirect_valid) begin
      // Everything still in flight after this edge belongs to the old stream.
      fetch_pc    <= target_pc;
      resp_pc     <= target_pc;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= outstanding_next;
      drop_cnt    <= outstanding_next;
`ifdef IF_MISALIGN_TRAP_EN
      halted        <= misaligned;
      fault_pending <= misaligned;
`endif
    end else begin
      outstanding <= outstanding_next;
      count       <= count + CW'(push) - CW'(pop);
      if (accept)    fetch_pc <= fetch_pc + STEP;
      if (drop)      drop_cnt <= drop_cnt - CW'(1);
      if (push)      wr_ptr   <= wr_ptr + AW'(1);
      if (pop)       rd_ptr   <= rd_ptr + AW'(1);
`ifdef IF_MISALIGN_TRAP_EN
      if (push_resp && !fault_pending) resp_pc <= resp_pc + STEP;
      fault_pending <= 1'b0;
`else
      if (push_resp) resp_pc <= resp_pc + STEP;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem[wr_ptr]    <= push_pc;
      instr_mem[wr_ptr] <= push_instr;
`ifdef IF_MISALIGN_TRAP_EN
      fault_mem[wr_ptr] <= fault_pending;
`endif
    end
  end
endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// Self-checking bench for pipeline_fetch_unit: in-order memory model, fetch-stream scoreboard,
// phase vector table and directed redirect/reset sequences. Fault checks active under IF_MISALIGN_TRAP_EN.
module tb_pipeline_fetch_unit;
  localparam int unsigned     XLEN  = 64;
  localparam int unsigned     ILEN  = 32;
  localparam int unsigned     DEPTH = 4;
  localparam logic [XLEN-1:0] RPC   = 64'h0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_fetch_unit_if #(.XLEN(XLEN), .ILEN(ILEN)) bus ();
  pipeline_fetch_unit #(.XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic [63:0] pc; logic [31:0] instr; logic fault; } entry_t;
  typedef struct { logic [63:0] addr; int due; } mreq_t;
  typedef struct {
    bit do_reset; int cycles; bit ready; bit gnt; int lat;
    int exp_acc; int exp_pop; logic [63:0] exp_first;
  } vec_t;

  entry_t      sb[$];
  mreq_t       mq[$];
  logic [63:0] pop_pcs[$];
  int checks = 0, errors = 0;
  int cyc = 0, lat = 1, last_due = 0;
  bit gnt_en = 1'b1;
  logic [63:0] exp_fetch = RPC;
  int buf_cnt = 0, stale = 0, total_out = 0, acc_cnt = 0, pop_cnt = 0;
  bit halted = 1'b0, fault_pending = 1'b0;
  logic s_req, s_valid;
  logic [63:0] s_addr;

  function automatic logic [31:0] fmem(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_counts();
    acc_cnt = 0;
    pop_cnt = 0;
    pop_pcs.delete();
  endtask

  // One clock: memory drives, outputs checked at negedge, model advanced, return #1 after posedge.
  task automatic tick();
    logic exp_req, exp_valid, rv, rdy, redir, gnt;
    logic [63:0] tgt;
    int tout_next, due;
    bus.im_gnt = gnt_en;
    if (!reset && mq.size() > 0 && mq[0].due <= cyc) begin
      bus.im_rvalid = 1'b1;
      bus.im_rdata  = fmem(mq[0].addr);
    end else begin
      bus.im_rvalid = 1'b0;
      bus.im_rdata  = $urandom;
    end
    @(negedge clk);
    rv = bus.im_rvalid; rdy = bus.if_ready; redir = bus.redirect_valid; gnt = bus.im_gnt;
    s_req = bus.im_req; s_addr = bus.im_addr; s_valid = bus.if_valid;
    exp_req   = !reset && !redir && !halted && (sb.size() + stale < int'(DEPTH));
    exp_valid = !reset && !redir && (buf_cnt > 0);
    check("im_req", s_req, exp_req);
    if (exp_req) check("im_addr", s_addr, exp_fetch);
    check("if_valid", s_valid, exp_valid);
    if (exp_valid && rdy && sb.size() > 0) begin
      check("if_pc", bus.if_pc, sb[0].pc);
      check("if_instr", bus.if_instr, sb[0].instr);
`ifdef IF_MISALIGN_TRAP_EN
      check("if_fault", bus.if_fault, sb[0].fault);
`endif
    end
    if (s_req && gnt) acc_cnt++;
    if (s_valid && rdy) begin
      pop_cnt++;
      pop_pcs.push_back(bus.if_pc);
    end
    if (reset) begin
      sb.delete(); mq.delete();
      exp_fetch = RPC; buf_cnt = 0; stale = 0; total_out = 0; last_due = 0;
      halted = 1'b0; fault_pending = 1'b0;
    end else begin
      if (s_req && gnt) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{addr: s_addr, due: due});
      end
      if (rv && mq.size() > 0) void'(mq.pop_front());
      tout_next = total_out + int'(s_req && gnt) - int'(rv);
      if (redir) begin
        tgt = bus.redirect_pc;
`ifndef IF_MISALIGN_TRAP_EN
        tgt[1:0] = 2'b00;
`endif
        sb.delete();
        buf_cnt = 0; stale = tout_next; exp_fetch = tgt;
        halted = 1'b0; fault_pending = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
        if (tgt[1:0] != 2'b00) begin
          halted = 1'b1; fault_pending = 1'b1;
          sb.push_back('{pc: tgt, instr: 32'h0, fault: 1'b1});
        end
`endif
      end else begin
        if (fault_pending) begin buf_cnt++; fault_pending = 1'b0; end
        if (exp_req && gnt) begin
          sb.push_back('{pc: exp_fetch, instr: fmem(exp_fetch), fault: 1'b0});
          exp_fetch += 64'd4;
        end
        if (rv) begin
          if (stale > 0) stale--;
          else buf_cnt++;
        end
        if (exp_valid && rdy && sb.size() > 0) begin
          void'(sb.pop_front());
          buf_cnt--;
        end
      end
      total_out = tout_next;
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic run_until_pops(input int n, input int budget);
    int k = 0;
    while (pop_cnt < n && k < budget) begin tick(); k++; end
    check("pops_reached", pop_cnt >= n, 1'b1);
  endtask

  task automatic redirect_to(input logic [63:0] pc);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = pc;
    tick();
    bus.redirect_valid = 1'b0;
  endtask

  function automatic logic [63:0] popped(input int i);
    return (pop_pcs.size() > i) ? pop_pcs[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  initial begin
    vec_t vecs[5];
    vecs[0] = '{do_reset: 1, cycles: 10, ready: 1, gnt: 1, lat: 1, exp_acc: 10, exp_pop: 8, exp_first: 64'h0};
    vecs[1] = '{do_reset: 0, cycles: 6,  ready: 1, gnt: 0, lat: 1, exp_acc: 0,  exp_pop: 2, exp_first: 64'd32};
    vecs[2] = '{do_reset: 1, cycles: 10, ready: 0, gnt: 1, lat: 1, exp_acc: 4,  exp_pop: 0, exp_first: 64'h0};
    vecs[3] = '{do_reset: 0, cycles: 5,  ready: 1, gnt: 1, lat: 1, exp_acc: 4,  exp_pop: 5, exp_first: 64'h0};
    vecs[4] = '{do_reset: 1, cycles: 6,  ready: 1, gnt: 0, lat: 1, exp_acc: 0,  exp_pop: 0, exp_first: 64'h0};

    reset = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.if_ready = 1'b1;
    bus.im_gnt = 1'b0; bus.im_rvalid = 1'b0; bus.im_rdata = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      lat = vecs[i].lat; gnt_en = vecs[i].gnt; bus.if_ready = vecs[i].ready;
      if (vecs[i].do_reset) do_reset();
      clear_counts();
      repeat (vecs[i].cycles) tick();
      check($sformatf("vec%0d_accepts", i), acc_cnt, vecs[i].exp_acc);
      check($sformatf("vec%0d_pops", i), pop_cnt, vecs[i].exp_pop);
      if (vecs[i].exp_pop > 0) check($sformatf("vec%0d_first_pc", i), popped(0), vecs[i].exp_first);
    end

    // Redirect with three slow responses in flight.
    lat = 5; gnt_en = 1'b1; bus.if_ready = 1'b1;
    do_reset();
    repeat (3) tick();
    redirect_to(64'h1000);
    check("redir3_req_low", s_req, 1'b0);
    check("redir3_valid_low", s_valid, 1'b0);
    clear_counts();
    tick();
    check("redir3_next_addr", s_addr, 64'h1000);
    check("redir3_next_req", s_req, 1'b1);
    run_until_pops(2, 40);
    check("redir3_pc0", popped(0), 64'h1000);
    check("redir3_pc1", popped(1), 64'h1004);

    // Redirect colliding with a response while two are outstanding.
    lat = 2;
    do_reset();
    repeat (2) tick();
    redirect_to(64'h2000);
    check("collide_valid_low", s_valid, 1'b0);
    check("collide_req_low", s_req, 1'b0);
    clear_counts();
    run_until_pops(1, 30);
    check("collide_pc0", popped(0), 64'h2000);

    // Reset with buffered entries and two requests in flight.
    lat = 3; bus.if_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    reset = 1'b1;
    tick();
    check("midrst_req_low", s_req, 1'b0);
    check("midrst_valid_low", s_valid, 1'b0);
    tick();
    check("midrst2_valid_low", s_valid, 1'b0);
    reset = 1'b0; bus.if_ready = 1'b1;
    tick();
    check("midrst_addr", s_addr, RPC);
    check("midrst_req", s_req, 1'b1);

    // PC wrap at the top of the address space.
    lat = 1;
    redirect_to(64'hFFFF_FFFF_FFFF_FFF8);
    clear_counts();
    run_until_pops(3, 30);
    check("wrap_pc0", popped(0), 64'hFFFF_FFFF_FFFF_FFF8);
    check("wrap_pc1", popped(1), 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_pc2", popped(2), 64'h0);

    // Misaligned redirect target.
    redirect_to(64'h3006);
    clear_counts();
`ifdef IF_MISALIGN_TRAP_EN
    run_until_pops(1, 30);
    check("fault_pc", popped(0), 64'h3006);
    repeat (5) tick();
    check("fault_halt_req", s_req, 1'b0);
    check("fault_single", pop_cnt, 1);
`else
    run_until_pops(2, 30);
    check("align_pc0", popped(0), 64'h3004);
    check("align_pc1", popped(1), 64'h3008);
`endif

    // Back-to-back redirects: the last target wins.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h4000;
    tick();
    bus.redirect_pc = 64'h5000;
    tick();
    bus.redirect_valid = 1'b0;
    clear_counts();
    run_until_pops(2, 30);
    check("b2b_pc0", popped(0), 64'h5000);
    check("b2b_pc1", popped(1), 64'h5004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
